// File: rtl/rcfwl_cdc_assert_en_gen.sv
// rtl/rcfwl_cdc_assert_en_gen.sv - synchronized, debounced assertion-enable generator (optional glitch counter: RCFWL_CDC_ASSERT_EN_GLITCH_CNT_EN)
module rcfwl_cdc_assert_en_gen #(
    parameter int SETTLE_CYCLES  = 4,
    parameter int HOLDOFF_CYCLES = 8,
    parameter int GLITCH_W       = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                pok_reset_b,
    output logic                assert_en,
    output logic                arm_pulse,
    output logic [1:0]          fsm_state
`ifdef RCFWL_CDC_ASSERT_EN_GLITCH_CNT_EN
    ,
    output logic [GLITCH_W-1:0] glitch_cnt
`endif
);

    localparam int CNT_MAX = (SETTLE_CYCLES > HOLDOFF_CYCLES) ? SETTLE_CYCLES : HOLDOFF_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLDOFF_LAST = CNT_W'(HOLDOFF_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_OFF    = 2'd0,
        ST_SETTLE = 2'd1,
        ST_ON     = 2'd2,
        ST_COOL   = 2'd3
    } state_t;

    // Reject parameter values that would make the terminal compares meaningless
    if (SETTLE_CYCLES < 1 || HOLDOFF_CYCLES < 1 || GLITCH_W < 1) begin : g_bad_param
        $error("rcfwl_cdc_assert_en_gen: SETTLE_CYCLES, HOLDOFF_CYCLES and GLITCH_W must be >= 1");
    end

    logic             r_pok_meta;
    logic             r_pok_s;
    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_assert_en;
    logic             r_arm_pulse;
    logic             w_settle_abort;

    // A settle is aborted whenever the synchronized level drops while still settling
    assign w_settle_abort = (r_state == ST_SETTLE) && !r_pok_s;

    // Two-flop synchronizer; only r_pok_s is used by the rest of the block
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pok_meta <= 1'b0;
            r_pok_s    <= 1'b0;
        end else begin
            r_pok_meta <= pok_reset_b;
            r_pok_s    <= r_pok_meta;
        end
    end

    // Debounce FSM; assert_en and arm_pulse are registered alongside the state
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_OFF;
            r_cnt       <= '0;
            r_assert_en <= 1'b0;
            r_arm_pulse <= 1'b0;
        end else begin
            r_arm_pulse <= 1'b0;
            case (r_state)
                ST_OFF: begin
                    if (r_pok_s) begin
                        r_state <= ST_SETTLE;
                        r_cnt   <= '0;
                    end
                end
                ST_SETTLE: begin
                    if (!r_pok_s) begin
                        r_state <= ST_OFF;
                    end else if (r_cnt == SETTLE_LAST) begin
                        r_state     <= ST_ON;
                        r_assert_en <= 1'b1;
                        r_arm_pulse <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_ON: begin
                    if (!r_pok_s) begin
                        r_state     <= ST_COOL;
                        r_cnt       <= '0;
                        r_assert_en <= 1'b0;
                    end
                end
                ST_COOL: begin
                    // Holdoff runs to completion regardless of the input level
                    if (r_cnt == HOLDOFF_LAST) begin
                        r_state <= ST_OFF;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state     <= ST_OFF;
                    r_assert_en <= 1'b0;
                end
            endcase
        end
    end

    assign assert_en = r_assert_en;
    assign arm_pulse = r_arm_pulse;
    assign fsm_state = r_state;

`ifdef RCFWL_CDC_ASSERT_EN_GLITCH_CNT_EN
    logic [GLITCH_W-1:0] r_glitch_cnt;

    // Saturating count of aborted settles, cleared only by rst
    always_ff @(posedge clk) begin
        if (rst) begin
            r_glitch_cnt <= '0;
        end else if (w_settle_abort && (r_glitch_cnt != {GLITCH_W{1'b1}})) begin
            r_glitch_cnt <= r_glitch_cnt + 1'b1;
        end
    end

    assign glitch_cnt = r_glitch_cnt;
`else
    logic w_settle_abort_unused;
    assign w_settle_abort_unused = w_settle_abort;
`endif

endmodule
